rv32i_encoder: RTL and testbench

Streaming RV32I instruction encoder: the inverse of the instruction decoder. It accepts field-level instruction descriptors (class, register indices, funct3/funct7, raw 32-bit immediate), packs them into 32-bit instruction words, range-checks the immediates, and emits each word with a sequential word address to the instruction-memory loader. It is used by the self-test program generator and the debug program loader to fill instruction memory ahead of the core.

---
 rtl/rv32i_pkg.sv | 55 +++++
 rtl/rv32i_encoder_if.sv | 32 +++
 rtl/rv32i_imm_pack.sv | 79 +++++++
 rtl/rv32i_encoder.sv | 101 ++++++++++
 tb/tb_rv32i_encoder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants: major opcodes, descriptor classes, error codes.
// Also holds small helpers used by the encoder datapath.
package rv32i_pkg;

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  typedef enum logic [3:0] {
    CLS_ALU    = 4'd0,
    CLS_ALU_I  = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LUI    = 4'd5,
    CLS_AUIPC  = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JALR   = 4'd8
  } instr_class_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_IMM      = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_CLASS    = 2'd3
  } err_code_e;

  // Full 7-bit opcode for a descriptor class; illegal classes map to zero.
  function automatic logic [6:0] opcode_of(input logic [3:0] cls);
    case (cls)
      CLS_ALU:    opcode_of = {OPC_OP,     2'b11};
      CLS_ALU_I:  opcode_of = {OPC_OP_IMM, 2'b11};
      CLS_LOAD:   opcode_of = {OPC_LOAD,   2'b11};
      CLS_STORE:  opcode_of = {OPC_STORE,  2'b11};
      CLS_BRANCH: opcode_of = {OPC_BRANCH, 2'b11};
      CLS_LUI:    opcode_of = {OPC_LUI,    2'b11};
      CLS_AUIPC:  opcode_of = {OPC_AUIPC,  2'b11};
      CLS_JAL:    opcode_of = {OPC_JAL,    2'b11};
      CLS_JALR:   opcode_of = {OPC_JALR,   2'b11};
      default:    opcode_of = 7'd0;
    endcase
  endfunction

  // True when the bits selected by mask are all zero or all one (sign extension intact).
  function automatic logic sign_run_ok(input logic [31:0] v, input logic [31:0] mask);
    sign_run_ok = ((v & mask) == 32'd0) || ((v & mask) == mask);
  endfunction

endpackage

// File: rtl/rv32i_encoder_if.sv
// Descriptor-in / word-out bus of the RV32I encoder, plus its status outputs.
interface rv32i_encoder_if #(parameter int ADDR_W = 10);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   count;

  modport master (
    output start, in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_word, out_addr, err, err_code, count
  );

  modport slave (
    input  start, in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_word, out_addr, err, err_code, count
  );
endinterface

// File: rtl/rv32i_imm_pack.sv
// Places the immediate into its instruction-word bit positions for each format
// and range-checks it; purely combinational.
module rv32i_imm_pack
  import rv32i_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic [1:0]  err_code
);

  logic fits_i_s;
  logic fits_b_s;
  logic fits_j_s;

  assign fits_i_s = sign_run_ok(imm, 32'hFFFF_F800);
  assign fits_b_s = sign_run_ok(imm, 32'hFFFF_F000);
  assign fits_j_s = sign_run_ok(imm, 32'hFFF0_0000);

  // Format selection; range errors take precedence over misalignment.
  always_comb begin
    imm_bits = 32'd0;
    err_code = ERR_NONE;
    case (cls)
      CLS_ALU: begin
        imm_bits = 32'd0;
        err_code = ERR_NONE;
      end
      CLS_ALU_I: begin
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          imm_bits = {funct7, imm[4:0], 20'd0};
          err_code = (imm[31:5] != 27'd0) ? ERR_IMM : ERR_NONE;
        end else begin
          imm_bits = {imm[11:0], 20'd0};
          err_code = fits_i_s ? ERR_NONE : ERR_IMM;
        end
      end
      CLS_LOAD, CLS_JALR: begin
        imm_bits = {imm[11:0], 20'd0};
        err_code = fits_i_s ? ERR_NONE : ERR_IMM;
      end
      CLS_STORE: begin
        imm_bits = {imm[11:5], 13'd0, imm[4:0], 7'd0};
        err_code = fits_i_s ? ERR_NONE : ERR_IMM;
      end
      CLS_BRANCH: begin
        imm_bits = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
        if (!fits_b_s) begin
          err_code = ERR_IMM;
        end else if (imm[0]) begin
          err_code = ERR_MISALIGN;
        end else begin
          err_code = ERR_NONE;
        end
      end
      CLS_LUI, CLS_AUIPC: begin
        imm_bits = {imm[31:12], 12'd0};
        err_code = (imm[11:0] != 12'd0) ? ERR_IMM : ERR_NONE;
      end
      CLS_JAL: begin
        imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
        if (!fits_j_s) begin
          err_code = ERR_IMM;
        end else if (imm[0]) begin
          err_code = ERR_MISALIGN;
        end else begin
          err_code = ERR_NONE;
        end
      end
      default: begin
        imm_bits = 32'd0;
        err_code = ERR_CLASS;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_encoder.sv
// Streaming RV32I encoder: packs field descriptors into instruction words and
// emits them with sequential word addresses through a one-deep output register.
module rv32i_encoder
  import rv32i_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  rv32i_encoder_if.slave bus
);

  localparam logic [ADDR_W-1:0] BASE_S = ADDR_W'(BASE_ADDR);

  logic [31:0]       imm_bits_s;
  logic [1:0]        pack_err_s;
  logic [31:0]       word_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              legal_s;
  logic              drain_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic [31:0]       out_word_r;
  logic              out_valid_r;
  logic [ADDR_W:0]   count_r;
  logic              err_r;
  logic [1:0]        err_code_r;

  rv32i_imm_pack u_imm_pack (
    .cls      (bus.in_class),
    .funct3   (bus.in_funct3),
    .funct7   (bus.in_funct7),
    .imm      (bus.in_imm),
    .imm_bits (imm_bits_s),
    .err_code (pack_err_s)
  );

  assign in_ready_s = rst_n && !bus.start && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign legal_s    = accept_s && (pack_err_s == ERR_NONE);
  assign drain_s    = out_valid_r && bus.out_ready;

  // Merge register/function fields used by each format with opcode and immediate.
  always_comb begin
    word_s = {25'd0, opcode_of(bus.in_class)} | imm_bits_s;
    case (bus.in_class)
      CLS_ALU:
        word_s = word_s | {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, 7'd0};
      CLS_ALU_I, CLS_LOAD:
        word_s = word_s | {12'd0, bus.in_rs1, bus.in_funct3, bus.in_rd, 7'd0};
      CLS_STORE, CLS_BRANCH:
        word_s = word_s | {7'd0, bus.in_rs2, bus.in_rs1, bus.in_funct3, 12'd0};
      CLS_LUI, CLS_AUIPC, CLS_JAL:
        word_s = word_s | {20'd0, bus.in_rd, 7'd0};
      CLS_JALR:
        word_s = word_s | {12'd0, bus.in_rs1, 3'b000, bus.in_rd, 7'd0};
      default:
        word_s = 32'd0;
    endcase
  end

  // Output register, address/count counters and sticky first-error capture.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.start) begin
      out_valid_r <= 1'b0;
      out_word_r  <= 32'd0;
      out_addr_r  <= BASE_S;
      addr_r      <= BASE_S;
      count_r     <= '0;
      err_r       <= 1'b0;
      err_code_r  <= ERR_NONE;
    end else begin
      if (drain_s) begin
        count_r <= count_r + (ADDR_W+1)'(1);
      end
      if (legal_s) begin
        out_valid_r <= 1'b1;
        out_word_r  <= word_s;
        out_addr_r  <= addr_r;
        addr_r      <= addr_r + ADDR_W'(1);
      end else if (drain_s) begin
        out_valid_r <= 1'b0;
      end
      if (accept_s && !legal_s && !err_r) begin
        err_r      <= 1'b1;
        err_code_r <= pack_err_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_word  = out_word_r;
  assign bus.out_addr  = out_addr_r;
  assign bus.err       = err_r;
  assign bus.err_code  = err_code_r;
  assign bus.count     = count_r;

endmodule

// File: tb/tb_rv32i_encoder.sv
// Directed bench for rv32i_encoder: hand-encoded words, backpressure, errors,
// start flush and address wrap on a narrow-address instance.
module tb_rv32i_encoder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  rv32i_encoder_if #(.ADDR_W(10)) bus ();
  rv32i_encoder_if #(.ADDR_W(2))  bus2 ();

  rv32i_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rv32i_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_class  = c;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Send one descriptor into an empty pipe and check the emitted word.
  task automatic one_word(input string tag, input logic [3:0] c, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] exp);
    drive(c, rd, rs1, rs2, f3, f7, imm);
    tick();
    idle();
    check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_val({tag, "_word"}, bus.out_word, exp);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;  bus.out_ready = 1'b1;
    drive(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle();
    bus2.start = 1'b0; bus2.out_ready = 1'b1; bus2.in_valid = 1'b0;
    bus2.in_class = 4'd0; bus2.in_rd = 5'd0; bus2.in_rs1 = 5'd0; bus2.in_rs2 = 5'd0;
    bus2.in_funct3 = 3'd0; bus2.in_funct7 = 7'd0; bus2.in_imm = 32'd0;
    repeat (2) tick();

    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_word", bus.out_word, 32'd0);
    check_val("rst_out_addr", 32'(bus.out_addr), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);
    check_val("rst_err_code", 32'(bus.err_code), 32'd0);
    check_val("rst_count", 32'(bus.count), 32'd0);
    bus.in_valid = 1'b1;
    #1 check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    idle();
    rst_n = 1'b1;

    // Basic R-type after reset
    drive(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    #1 check_val("alu_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    check_val("alu_valid", 32'(bus.out_valid), 32'd1);
    check_val("alu_word", bus.out_word, 32'h002081B3);
    check_val("alu_addr", 32'(bus.out_addr), 32'd0);
    check_val("alu_count_pre", 32'(bus.count), 32'd0);
    tick();
    check_val("alu_count_post", 32'(bus.count), 32'd1);
    check_val("alu_valid_drop", 32'(bus.out_valid), 32'd0);

    // Back-to-back ALU_I then BRANCH
    pulse_start();
    drive(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    tick();
    check_val("alui_word", bus.out_word, 32'hFFF00093);
    check_val("alui_addr", 32'(bus.out_addr), 32'd0);
    drive(4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    tick();
    idle();
    check_val("br_valid", 32'(bus.out_valid), 32'd1);
    check_val("br_word", bus.out_word, 32'hFE000EE3);
    check_val("br_addr", 32'(bus.out_addr), 32'd1);
    tick();
    check_val("b2b_count", 32'(bus.count), 32'd2);

    // JAL, misaligned JAL, then range error keeps first code
    pulse_start();
    drive(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    check_val("jal_word", bus.out_word, 32'h001000EF);
    check_val("jal_addr", 32'(bus.out_addr), 32'd0);
    drive(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick();
    check_val("jal_mis_valid", 32'(bus.out_valid), 32'd0);
    check_val("jal_mis_err", 32'(bus.err), 32'd1);
    check_val("jal_mis_code", 32'(bus.err_code), 32'd2);
    check_val("jal_mis_count", 32'(bus.count), 32'd1);
    drive(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    check_val("range_keep_code", 32'(bus.err_code), 32'd2);
    check_val("range_valid", 32'(bus.out_valid), 32'd0);
    drive(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    idle();
    check_val("after_err_word", bus.out_word, 32'h002081B3);
    check_val("after_err_addr", 32'(bus.out_addr), 32'd1);
    tick();

    // Backpressure with two descriptors queued
    pulse_start();
    bus.out_ready = 1'b0;
    drive(4'd1, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    drive(4'd5, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    for (int i = 0; i < 3; i++) begin
      #1 check_val("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_val("bp_word", bus.out_word, 32'h00510293);
      check_val("bp_addr", 32'(bus.out_addr), 32'd0);
      check_val("bp_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    idle();
    check_val("bp_word2", bus.out_word, 32'h123453B7);
    check_val("bp_addr2", 32'(bus.out_addr), 32'd1);
    tick();
    check_val("bp_count", 32'(bus.count), 32'd2);
    check_val("bp_valid_end", 32'(bus.out_valid), 32'd0);

    // Illegal class, pending store, then start flushes everything
    bus.out_ready = 1'b0;
    drive(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    check_val("ill_err", 32'(bus.err), 32'd1);
    check_val("ill_code", 32'(bus.err_code), 32'd3);
    check_val("ill_valid", 32'(bus.out_valid), 32'd0);
    drive(4'd3, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd8);
    tick();
    check_val("sw_valid", 32'(bus.out_valid), 32'd1);
    check_val("sw_word", bus.out_word, 32'h00312423);
    check_val("sw_addr", 32'(bus.out_addr), 32'd2);
    bus.start = 1'b1;
    drive(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    #1 check_val("start_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.start = 1'b0;
    check_val("start_valid", 32'(bus.out_valid), 32'd0);
    check_val("start_count", 32'(bus.count), 32'd0);
    check_val("start_err", 32'(bus.err), 32'd0);
    check_val("start_code", 32'(bus.err_code), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    idle();
    check_val("post_start_word", bus.out_word, 32'h002081B3);
    check_val("post_start_addr", 32'(bus.out_addr), 32'd0);
    tick();

    // JALR forces funct3, shift immediate form, and shift range error
    pulse_start();
    one_word("jalr", 4'd8, 5'd1, 5'd2, 5'd0, 3'd7, 7'd0, 32'hFFFF_FFF8, 32'hFF8100E7);
    one_word("srai", 4'd1, 5'd4, 5'd4, 5'd0, 3'd5, 7'h20, 32'd3, 32'h40325213);
    drive(4'd1, 5'd4, 5'd4, 5'd0, 3'd1, 7'd0, 32'd32);
    tick();
    idle();
    check_val("sh_range_code", 32'(bus.err_code), 32'd1);
    check_val("sh_range_valid", 32'(bus.out_valid), 32'd0);

    // Address wrap on the 2-bit instance
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        check_val("wrap_addr", 32'(bus2.out_addr), 32'((i - 1) % 4));
        check_val("wrap_word", bus2.out_word, (32'(i - 1) << 12) | (32'(i - 1) << 7) | 32'h17);
      end
      if (i < 5) begin
        bus2.in_valid = 1'b1;
        bus2.in_class = 4'd6;
        bus2.in_rd    = 5'(i);
        bus2.in_imm   = 32'(i) << 12;
      end else begin
        bus2.in_valid = 1'b0;
      end
      tick();
    end
    check_val("wrap_count", 32'(bus2.count), 32'd5);
    check_val("wrap_valid", 32'(bus2.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
